// File: rtl/bin_down_counter_if.sv
// Control/status bundle for bin_down_counter: load/run requests in, count and status out.
interface bin_down_counter_if #(
  parameter int COUNTER_WIDTH = 4
);
  logic                     load;
  logic [COUNTER_WIDTH-1:0] load_value;
  logic                     en;
  logic                     abort;
  logic [COUNTER_WIDTH-1:0] data_out;
  logic                     busy;
  logic                     done;

  modport master (
    output load, load_value, en, abort,
    input  data_out, busy, done
  );

  modport slave (
    input  load, load_value, en, abort,
    output data_out, busy, done
  );
endinterface

// File: rtl/bin_down_counter.sv
// Loadable binary down counter with IDLE/RUN control and a registered terminal-count pulse.
// Define BIN_DOWN_COUNTER_AUTORELOAD_EN to reload the last loaded value at terminal count.
module bin_down_counter #(
  parameter int COUNTER_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  bin_down_counter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] count, count_nxt;
  logic                     done_q, done_nxt;

`ifdef BIN_DOWN_COUNTER_AUTORELOAD_EN
  logic [COUNTER_WIDTH-1:0] reload, reload_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reload <= '0;
    else      reload <= reload_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
`ifdef BIN_DOWN_COUNTER_AUTORELOAD_EN
    reload_nxt = reload;
`endif
    case (state)
      IDLE: begin
        // abort outranks load; a zero load terminates immediately
        if (!bus.abort && bus.load) begin
          count_nxt = bus.load_value;
`ifdef BIN_DOWN_COUNTER_AUTORELOAD_EN
          reload_nxt = bus.load_value;
`endif
          if (bus.load_value != '0) state_nxt = RUN;
          else                      done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (bus.en) begin
          if (count > COUNTER_WIDTH'(1)) begin
            count_nxt = count - COUNTER_WIDTH'(1);
          end else begin
            done_nxt = 1'b1;
`ifdef BIN_DOWN_COUNTER_AUTORELOAD_EN
            count_nxt = reload;
`else
            count_nxt = '0;
            state_nxt = IDLE;
`endif
          end
        end
      end
      default: begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.data_out = count;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;

endmodule
